// File: rtl/mem_stage_if.sv
// Execute-to-writeback pipeline bundle for the memory stage, plus the decode bypass view.
// Combinational only; carries signals and adds no latency.
// Backpressure flows through mem_allowin (toward execute) and wb_allowin (from writeback).
interface mem_stage_if #(
   parameter int EX_BUS_W = 104,
   parameter int WB_BUS_W = 70
);
   logic                ex_to_mem_valid;
   logic [EX_BUS_W-1:0] ex_reg;
   logic                mem_allowin;
   logic                wb_allowin;
   logic                mem_to_wb_valid;
   logic [WB_BUS_W-1:0] mem_reg;
   logic                data_sram_data_ok;
   logic [31:0]         data_sram_rdata;
   logic                mem_fwd_valid;
   logic [4:0]          mem_fwd_dest;
   logic [31:0]         mem_fwd_data;
   logic                mem_fwd_ready;

   // The memory stage itself
   modport master (
      input  ex_to_mem_valid, ex_reg, wb_allowin, data_sram_data_ok, data_sram_rdata,
      output mem_allowin, mem_to_wb_valid, mem_reg,
             mem_fwd_valid, mem_fwd_dest, mem_fwd_data, mem_fwd_ready
   );

   // Surrounding pipeline: execute, writeback, data SRAM and decode
   modport slave (
      output ex_to_mem_valid, ex_reg, wb_allowin, data_sram_data_ok, data_sram_rdata,
      input  mem_allowin, mem_to_wb_valid, mem_reg,
             mem_fwd_valid, mem_fwd_dest, mem_fwd_data, mem_fwd_ready
   );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: captures the execute bus, completes loads from data_ok, selects the writeback value.
// Latency: non-load 1 cycle; load leaves on its data_ok cycle at the earliest.
// Backpressure: wb_allowin=0 holds the instruction (load data parked in hold_data), mem_allowin drops.
module mem_stage #(
   parameter int EX_BUS_W = 104,
   parameter int WB_BUS_W = 70,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             resetn,
   mem_stage_if.master      bus,
   output logic             mem_resp_err,
   output logic [CNT_W-1:0] load_stall_cnt
);

   logic                mem_valid;
   logic [EX_BUS_W-1:0] ex_reg_q;
   logic                hold_v;
   logic [31:0]         hold_data;

   logic                is_load;
   logic                gr_we;
   logic [4:0]          dest;
   logic [31:0]         alu_result;
   logic [31:0]         pc;
   logic                data_ok;
   logic                mem_ready_go;
   logic                mem_allowin;
   logic                depart;
   logic                hold_capture;
   logic                resp_bad;
   logic [31:0]         load_data;
   logic [31:0]         final_result;
   logic [WB_BUS_W-1:0] wb_bus;
   logic                unused_ex_bits;

   // Field decode of the captured execute bus. mem_we and rkd_value are carried
   // but not needed here: stores already completed in execute.
   assign is_load        = ex_reg_q[103];
   assign gr_we          = ex_reg_q[101];
   assign dest           = ex_reg_q[100:96];
   assign alu_result     = ex_reg_q[95:64];
   assign pc             = ex_reg_q[31:0];
   assign unused_ex_bits = ^{ex_reg_q[102], ex_reg_q[63:32]};

   assign data_ok      = bus.data_sram_data_ok;
   assign mem_ready_go = !is_load || data_ok || hold_v;
   assign mem_allowin  = !mem_valid || (mem_ready_go && bus.wb_allowin);
   assign depart       = mem_valid && mem_ready_go && bus.wb_allowin;

   // Data arrived for the waiting load but writeback is blocked: park it, since
   // the SRAM read bus is only meaningful during the strobe.
   assign hold_capture = data_ok && mem_valid && is_load && !hold_v && !bus.wb_allowin;

   // A strobe with no load waiting for it breaks the one-outstanding-load rule.
   assign resp_bad = data_ok && (!mem_valid || !is_load || hold_v);

   assign load_data    = hold_v ? hold_data : bus.data_sram_rdata;
   assign final_result = is_load ? load_data : alu_result;
   assign wb_bus       = {gr_we, dest, final_result, pc};

   assign bus.mem_allowin     = mem_allowin;
   assign bus.mem_to_wb_valid = mem_valid && mem_ready_go;
   assign bus.mem_reg         = wb_bus;
   assign bus.mem_fwd_valid   = mem_valid && gr_we;
   assign bus.mem_fwd_dest    = dest;
   assign bus.mem_fwd_data    = final_result;
   assign bus.mem_fwd_ready   = mem_ready_go;

   // Stage occupancy: refreshed whenever the stage can accept, so depart and
   // arrive in the same cycle leave no bubble.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mem_valid <= 1'b0;
      end else if (mem_allowin) begin
         mem_valid <= bus.ex_to_mem_valid;
      end
   end

   // Instruction payload capture; contents are don't-care while mem_valid=0.
   always_ff @(posedge clk) begin
      if (bus.ex_to_mem_valid && mem_allowin) begin
         ex_reg_q <= bus.ex_reg;
      end
   end

   // Parked-load flag: set on a blocked data_ok, cleared when the load leaves.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         hold_v <= 1'b0;
      end else if (depart) begin
         hold_v <= 1'b0;
      end else if (hold_capture) begin
         hold_v <= 1'b1;
      end
   end

   // Parked load data, qualified by hold_v.
   always_ff @(posedge clk) begin
      if (hold_capture) begin
         hold_data <= bus.data_sram_rdata;
      end
   end

   // Sticky protocol-error flag, cleared only by reset.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mem_resp_err <= 1'b0;
      end else if (resp_bad) begin
         mem_resp_err <= 1'b1;
      end
   end

   // Load-wait cycle counter; wraps freely.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         load_stall_cnt <= '0;
      end else if (mem_valid && is_load && !mem_ready_go) begin
         load_stall_cnt <= load_stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: reset, ALU stream, load completion, hold path, errors, counter wrap.
// Inputs change 1 time unit after each rising edge; outputs are sampled on the falling edge.
// A second instance with a 2-bit counter exercises the wrap using the same stimulus.
module tb_mem_stage;

   logic clk;
   logic resetn;
   int   checks;
   int   errors;

   logic       err_main;
   logic [31:0] cnt_main;
   logic       err_w;
   logic [1:0] cnt_w;

   mem_stage_if #(.EX_BUS_W(104), .WB_BUS_W(70)) if0 ();
   mem_stage_if #(.EX_BUS_W(104), .WB_BUS_W(70)) ifw ();

   assign ifw.ex_to_mem_valid   = if0.ex_to_mem_valid;
   assign ifw.ex_reg            = if0.ex_reg;
   assign ifw.wb_allowin        = if0.wb_allowin;
   assign ifw.data_sram_data_ok = if0.data_sram_data_ok;
   assign ifw.data_sram_rdata   = if0.data_sram_rdata;

   mem_stage #(.EX_BUS_W(104), .WB_BUS_W(70), .CNT_W(32)) dut (
      .clk            (clk),
      .resetn         (resetn),
      .bus            (if0),
      .mem_resp_err   (err_main),
      .load_stall_cnt (cnt_main)
   );

   mem_stage #(.EX_BUS_W(104), .WB_BUS_W(70), .CNT_W(2)) dut_w (
      .clk            (clk),
      .resetn         (resetn),
      .bus            (ifw),
      .mem_resp_err   (err_w),
      .load_stall_cnt (cnt_w)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   function automatic logic [103:0] mk_ex(input logic ld, input logic we, input logic [4:0] d,
                                          input logic [31:0] alu, input logic [31:0] pc);
      return {ld, 1'b0, we, d, alu, 32'h5A5A_5A5A, pc};
   endfunction

   function automatic logic [69:0] mk_wb(input logic we, input logic [4:0] d,
                                         input logic [31:0] res, input logic [31:0] pc);
      return {we, d, res, pc};
   endfunction

   task automatic drv_ex(input logic v, input logic [103:0] b);
      if0.ex_to_mem_valid = v;
      if0.ex_reg          = b;
   endtask

   task automatic drv_ok(input logic ok, input logic [31:0] rd);
      if0.data_sram_data_ok = ok;
      if0.data_sram_rdata   = rd;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      resetn = 1'b0;
      drv_ex(1'b0, '0);
      drv_ok(1'b0, 32'h0);
      if0.wb_allowin = 1'b1;

      // Reset values
      cyc();
      cyc();
      mid();
      chk("rst_to_wb_valid", if0.mem_to_wb_valid, 0);
      chk("rst_allowin", if0.mem_allowin, 1);
      chk("rst_fwd_valid", if0.mem_fwd_valid, 0);
      chk("rst_err", err_main, 0);
      chk("rst_cnt", cnt_main, 0);
      cyc();
      resetn = 1'b1;

      // Load enters and waits; reset lands mid-load
      drv_ex(1'b1, mk_ex(1'b1, 1'b1, 5'd5, 32'h0, 32'h1C00_0010));
      mid();
      chk("ld_enter_allowin", if0.mem_allowin, 1);
      cyc();
      drv_ex(1'b0, '0);
      mid();
      chk("ld_wait_to_wb_valid", if0.mem_to_wb_valid, 0);
      chk("ld_wait_allowin", if0.mem_allowin, 0);
      chk("ld_wait_fwd_ready", if0.mem_fwd_ready, 0);
      chk("ld_wait_fwd_valid", if0.mem_fwd_valid, 1);
      chk("ld_wait_fwd_dest", if0.mem_fwd_dest, 5);
      cyc();
      mid();
      chk("ld_wait_cnt", cnt_main, 1);
      #1;
      resetn = 1'b0;
      #1;
      chk("midrst_to_wb_valid", if0.mem_to_wb_valid, 0);
      chk("midrst_allowin", if0.mem_allowin, 1);
      chk("midrst_fwd_valid", if0.mem_fwd_valid, 0);
      chk("midrst_cnt", cnt_main, 0);
      cyc();
      resetn = 1'b1;
      cyc();
      drv_ok(1'b1, 32'h1111_2222);
      mid();
      chk("orphan_ok_err_before", err_main, 0);
      cyc();
      drv_ok(1'b0, 32'h0);
      mid();
      chk("orphan_ok_err_after", err_main, 1);
      cyc();

      // Clear the sticky flag
      resetn = 1'b0;
      cyc();
      resetn = 1'b1;
      mid();
      chk("err_cleared", err_main, 0);
      cyc();

      // Back-to-back non-loads, no bubbles
      drv_ex(1'b1, mk_ex(1'b0, 1'b1, 5'd1, 32'h11, 32'h100));
      mid();
      chk("alu0_to_wb_valid", if0.mem_to_wb_valid, 0);
      chk("alu0_allowin", if0.mem_allowin, 1);
      cyc();
      drv_ex(1'b1, mk_ex(1'b0, 1'b1, 5'd2, 32'h22, 32'h104));
      mid();
      chk("alu1_mem_reg", if0.mem_reg, mk_wb(1'b1, 5'd1, 32'h11, 32'h100));
      chk("alu1_allowin", if0.mem_allowin, 1);
      cyc();
      drv_ex(1'b1, mk_ex(1'b0, 1'b1, 5'd3, 32'h33, 32'h108));
      mid();
      chk("alu2_mem_reg", if0.mem_reg, mk_wb(1'b1, 5'd2, 32'h22, 32'h104));
      chk("alu2_allowin", if0.mem_allowin, 1);
      cyc();
      drv_ex(1'b0, '0);
      mid();
      chk("alu3_mem_reg", if0.mem_reg, mk_wb(1'b1, 5'd3, 32'h33, 32'h108));
      chk("alu3_to_wb_valid", if0.mem_to_wb_valid, 1);
      chk("alu3_allowin", if0.mem_allowin, 1);
      cyc();
      mid();
      chk("alu_drained", if0.mem_to_wb_valid, 0);
      cyc();

      // Load whose data_ok arrives in its first MEM cycle
      drv_ex(1'b1, mk_ex(1'b1, 1'b1, 5'd7, 32'h0000_0200, 32'h200));
      cyc();
      drv_ex(1'b0, '0);
      drv_ok(1'b1, 32'hDEAD_BEEF);
      mid();
      chk("same_to_wb_valid", if0.mem_to_wb_valid, 1);
      chk("same_mem_reg", if0.mem_reg, mk_wb(1'b1, 5'd7, 32'hDEAD_BEEF, 32'h200));
      chk("same_fwd_ready", if0.mem_fwd_ready, 1);
      chk("same_fwd_data", if0.mem_fwd_data, 32'hDEAD_BEEF);
      cyc();
      drv_ok(1'b0, 32'h0);
      mid();
      chk("same_cnt", cnt_main, 0);
      chk("same_to_wb_drained", if0.mem_to_wb_valid, 0);
      chk("same_err", err_main, 0);
      cyc();

      // Load with data_ok three cycles after entry
      drv_ex(1'b1, mk_ex(1'b1, 1'b1, 5'd9, 32'h0, 32'h300));
      cyc();
      drv_ex(1'b0, '0);
      for (int i = 0; i < 3; i++) begin
         mid();
         chk("dly_fwd_ready", if0.mem_fwd_ready, 0);
         chk("dly_allowin", if0.mem_allowin, 0);
         cyc();
      end
      drv_ok(1'b1, 32'h1234_5678);
      mid();
      chk("dly_cnt", cnt_main, 3);
      chk("dly_fwd_ready_go", if0.mem_fwd_ready, 1);
      chk("dly_fwd_data", if0.mem_fwd_data, 32'h1234_5678);
      chk("dly_mem_reg", if0.mem_reg, mk_wb(1'b1, 5'd9, 32'h1234_5678, 32'h300));
      chk("dly_to_wb_valid", if0.mem_to_wb_valid, 1);
      cyc();
      drv_ok(1'b0, 32'h0);
      mid();
      chk("dly_cnt_after", cnt_main, 3);
      chk("dly_drained", if0.mem_to_wb_valid, 0);
      cyc();

      // Data arrives while writeback is blocked for two cycles
      drv_ex(1'b1, mk_ex(1'b1, 1'b1, 5'd10, 32'h0, 32'h400));
      if0.wb_allowin = 1'b0;
      cyc();
      drv_ex(1'b0, '0);
      drv_ok(1'b1, 32'hCAFE_F00D);
      mid();
      chk("hold_h1_to_wb_valid", if0.mem_to_wb_valid, 1);
      chk("hold_h1_allowin", if0.mem_allowin, 0);
      cyc();
      drv_ok(1'b0, 32'h0);
      mid();
      chk("hold_h2_mem_reg", if0.mem_reg, mk_wb(1'b1, 5'd10, 32'hCAFE_F00D, 32'h400));
      chk("hold_h2_allowin", if0.mem_allowin, 0);
      chk("hold_h2_hold_v", dut.hold_v, 1);
      cyc();
      if0.wb_allowin = 1'b1;
      mid();
      chk("hold_h3_mem_reg", if0.mem_reg, mk_wb(1'b1, 5'd10, 32'hCAFE_F00D, 32'h400));
      chk("hold_h3_allowin", if0.mem_allowin, 1);
      cyc();
      mid();
      chk("hold_cleared", dut.hold_v, 0);
      chk("hold_drained", if0.mem_to_wb_valid, 0);
      chk("hold_err", err_main, 0);
      chk("hold_cnt", cnt_main, 3);
      cyc();

      // data_ok during a non-load held by backpressure
      drv_ex(1'b1, mk_ex(1'b0, 1'b1, 5'd3, 32'hAAAA_5555, 32'h500));
      cyc();
      drv_ex(1'b0, '0);
      drv_ok(1'b1, 32'h0BAD_F00D);
      if0.wb_allowin = 1'b0;
      mid();
      chk("nl_ok_result", if0.mem_fwd_data, 32'hAAAA_5555);
      chk("nl_ok_err_before", err_main, 0);
      cyc();
      drv_ok(1'b0, 32'h0);
      mid();
      chk("nl_ok_err", err_main, 1);
      chk("nl_ok_mem_reg_stable", if0.mem_reg, mk_wb(1'b1, 5'd3, 32'hAAAA_5555, 32'h500));
      chk("nl_ok_allowin", if0.mem_allowin, 0);
      cyc();
      if0.wb_allowin = 1'b1;
      cyc();

      // Counter wrap: the 2-bit instance sits at all-ones after the three-cycle stall
      drv_ex(1'b1, mk_ex(1'b1, 1'b0, 5'd0, 32'h0, 32'h600));
      mid();
      chk("wrap_pre_w", cnt_w, 2'b11);
      cyc();
      drv_ex(1'b0, '0);
      mid();
      chk("wrap_stall_fwd_ready", ifw.mem_fwd_ready, 0);
      cyc();
      drv_ok(1'b1, 32'h7777_8888);
      mid();
      chk("wrap_w_cnt", cnt_w, 2'b00);
      chk("wrap_main_cnt", cnt_main, 4);
      chk("wrap_w_err", err_w, 1);
      cyc();
      drv_ok(1'b0, 32'h0);
      mid();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
